// File: rtl/load_store_unit.sv
// Single-port load/store unit: one request at a time, fixed LATENCY-cycle memory
// access, byte-lane stores, sign/zero-extended byte loads, misaligned-word detection.

module lsu_lane #(
   parameter int IW = 7
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [IW-1:0] idx,
   input  logic [7:0]    wbyte,
   output logic [7:0]    rbyte
);
   logic [7:0] mem [0:(1<<IW)-1];

   // Read returns the pre-write contents; loads never write, so this only matters for stores.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[idx] <= wbyte;
         rbyte <= mem[idx];
      end
   end
endmodule

module load_store_unit #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2,
   parameter int RD_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_byte,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [RD_W-1:0]   req_rd,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [RD_W-1:0]   resp_rd,
   output logic              resp_err,
   output logic              stall
);
   localparam int NUM_LANES = DATA_W / 8;
   localparam int LB        = $clog2(NUM_LANES);
   localparam int IW        = ADDR_W - LB;
   localparam int CW        = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef struct packed {
      logic              write;
      logic              byte_acc;
      logic              sgn;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [RD_W-1:0]   rd;
   } lsu_req_t;

   state_t   state, state_nxt;
   logic [CW-1:0] cnt;
   lsu_req_t req_q;
   logic     accept, mem_en, misaligned;
   logic [LB-1:0] lane_sel;
   logic [NUM_LANES-1:0][7:0] rword;
   logic [NUM_LANES-1:0]      lane_we;
   logic [7:0] rbyte;

   assign accept     = (state == IDLE) && req_valid;
   assign req_ready  = (state == IDLE);
   assign stall      = req_valid && !req_ready;
   assign lane_sel   = req_q.addr[LB-1:0];
   assign misaligned = !req_q.byte_acc && (lane_sel != '0);
   // Memory is touched only on the BUSY->DONE edge; reset on that edge suppresses it.
   assign mem_en     = (state == BUSY) && (cnt == CW'(1)) && !rst;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = BUSY;
         BUSY:    if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            req_q.write    <= req_write;
            req_q.byte_acc <= req_byte;
            req_q.sgn      <= req_signed;
            req_q.addr     <= req_addr;
            req_q.wdata    <= req_wdata;
            req_q.rd       <= req_rd;
            cnt            <= CW'(LATENCY);
         end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   genvar i;
   generate
      for (i = 0; i < NUM_LANES; i++) begin : g_lane
         assign lane_we[i] = req_q.write && !misaligned &&
                             (!req_q.byte_acc || (lane_sel == LB'(i)));
         lsu_lane #(.IW(IW)) u_lane (
            .clk   (clk),
            .en    (mem_en),
            .we    (lane_we[i]),
            .idx   (req_q.addr[ADDR_W-1:LB]),
            .wbyte (req_q.byte_acc ? req_q.wdata[7:0] : req_q.wdata[i*8 +: 8]),
            .rbyte (rword[i])
         );
      end
   endgenerate

   assign rbyte = rword[lane_sel];

   always_comb begin
      resp_valid = (state == DONE);
      resp_rdata = '0;
      resp_rd    = '0;
      resp_err   = 1'b0;
      if (state == DONE) begin
         resp_rd  = req_q.rd;
         resp_err = misaligned;
         if (!req_q.write && !misaligned) begin
            if (req_q.byte_acc)
               resp_rdata = {{(DATA_W-8){req_q.sgn & rbyte[7]}}, rbyte};
            else
               resp_rdata = rword;
         end
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: two unit instances (16-bit/LATENCY 2 and 32-bit/LATENCY 4),
// expected responses queued at issue and compared on each resp_valid pulse.

module tb_load_store_unit;
   localparam int LAT_A = 2;
   localparam int LAT_B = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        a_valid = 0, a_write = 0, a_byte = 0, a_signed = 0;
   logic [7:0]  a_addr = 0;
   logic [15:0] a_wdata = 0;
   logic [3:0]  a_rd = 0;
   logic        a_ready, a_rvalid, a_err, a_stall;
   logic [15:0] a_rdata;
   logic [3:0]  a_rrd;

   logic        b_valid = 0, b_write = 0, b_byte = 0, b_signed = 0;
   logic [7:0]  b_addr = 0;
   logic [31:0] b_wdata = 0;
   logic [3:0]  b_rd = 0;
   logic        b_ready, b_rvalid, b_err, b_stall;
   logic [31:0] b_rdata;
   logic [3:0]  b_rrd;

   load_store_unit #(.DATA_W(16), .ADDR_W(8), .LATENCY(LAT_A), .RD_W(4)) u_a (
      .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
      .req_write(a_write), .req_byte(a_byte), .req_signed(a_signed),
      .req_addr(a_addr), .req_wdata(a_wdata), .req_rd(a_rd),
      .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_rd(a_rrd),
      .resp_err(a_err), .stall(a_stall));

   load_store_unit #(.DATA_W(32), .ADDR_W(8), .LATENCY(LAT_B), .RD_W(4)) u_b (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
      .req_write(b_write), .req_byte(b_byte), .req_signed(b_signed),
      .req_addr(b_addr), .req_wdata(b_wdata), .req_rd(b_rd),
      .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_rd(b_rrd),
      .resp_err(b_err), .stall(b_stall));

   typedef struct {
      logic [31:0] data;
      logic [3:0]  rd;
      logic        err;
   } exp_t;

   exp_t qa[$], qb[$];
   int   ta[$], tb_q[$];
   int   pulse_t[$];
   int   cyc = 0;
   int   n_chk = 0, n_err = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Accept edges are numbered by cyc; the response is seen half a cycle after edge k+LATENCY.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && a_valid && a_ready) ta.push_back(cyc);
      if (!rst && b_valid && b_ready) tb_q.push_back(cyc);
   end

   always @(negedge clk) begin
      exp_t e;
      if (a_rvalid) begin
         pulse_t.push_back(cyc);
         if (qa.size() == 0) check("a_unexpected_resp", 1, 0);
         else begin
            e = qa.pop_front();
            check("a_rdata", 32'(a_rdata), e.data);
            check("a_resp_rd", 32'(a_rrd), 32'(e.rd));
            check("a_resp_err", 32'(a_err), 32'(e.err));
         end
         if (ta.size() == 0) check("a_latency_missing", 1, 0);
         else check("a_latency", 32'(cyc - ta.pop_front()), LAT_A + 1);
      end else
         check("a_idle_zero", 32'(a_rdata != 0 || a_rrd != 0 || a_err), 0);
      if (b_rvalid) begin
         if (qb.size() == 0) check("b_unexpected_resp", 1, 0);
         else begin
            e = qb.pop_front();
            check("b_rdata", b_rdata, e.data);
            check("b_resp_rd", 32'(b_rrd), 32'(e.rd));
            check("b_resp_err", 32'(b_err), 32'(e.err));
         end
         if (tb_q.size() == 0) check("b_latency_missing", 1, 0);
         else check("b_latency", 32'(cyc - tb_q.pop_front()), LAT_B + 1);
      end else
         check("b_idle_zero", 32'(b_rdata != 0 || b_rrd != 0 || b_err), 0);
   end

   task automatic a_drain();
      for (int i = 0; i < 40 && qa.size() != 0; i++) @(negedge clk);
      if (qa.size() != 0) begin
         check("a_resp_timeout", 32'(qa.size()), 0);
         qa.delete();
      end
   endtask

   task automatic b_drain();
      for (int i = 0; i < 40 && qb.size() != 0; i++) @(negedge clk);
      if (qb.size() != 0) begin
         check("b_resp_timeout", 32'(qb.size()), 0);
         qb.delete();
      end
   endtask

   // Called at a negedge; returns at the negedge after acceptance (keep=1) or after the response.
   task automatic a_req(bit w, bit bt, bit sg, logic [7:0] ad, logic [15:0] wd,
                        logic [3:0] rd, logic [15:0] ed, bit ee, bit keep = 0);
      exp_t e;
      a_valid = 1; a_write = w; a_byte = bt; a_signed = sg;
      a_addr = ad; a_wdata = wd; a_rd = rd;
      e.data = 32'(ed); e.rd = rd; e.err = ee;
      qa.push_back(e);
      for (int i = 0; i < 20 && !a_ready; i++) @(negedge clk);
      if (!a_ready) begin
         check("a_accept_timeout", 0, 1);
         a_valid = 0;
         qa.delete();
         return;
      end
      @(negedge clk);
      if (keep) begin
         check("a_stall_busy", 32'(a_stall), 1);
         check("a_ready_busy", 32'(a_ready), 0);
      end else begin
         a_valid = 0;
         a_drain();
      end
   endtask

   task automatic b_req(bit w, bit bt, bit sg, logic [7:0] ad, logic [31:0] wd,
                        logic [3:0] rd, logic [31:0] ed, bit ee);
      exp_t e;
      b_valid = 1; b_write = w; b_byte = bt; b_signed = sg;
      b_addr = ad; b_wdata = wd; b_rd = rd;
      e.data = ed; e.rd = rd; e.err = ee;
      qb.push_back(e);
      for (int i = 0; i < 20 && !b_ready; i++) @(negedge clk);
      if (!b_ready) begin
         check("b_accept_timeout", 0, 1);
         b_valid = 0;
         qb.delete();
         return;
      end
      @(negedge clk);
      b_valid = 0;
      b_drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(a_ready), 1);
      check("rst_resp_valid", 32'(a_rvalid), 0);
      check("rst_stall", 32'(a_stall), 0);
      check("rst_b_ready", 32'(b_ready), 1);
      rst = 0;
      @(negedge clk);

      // Preload words used later as "prior value" references.
      a_req(1, 0, 0, 8'h20, 16'hCAFE, 4'd1, 16'h0000, 0);
      a_req(1, 0, 0, 8'h30, 16'h5555, 4'd2, 16'h0000, 0);

      // Word store then load.
      a_req(1, 0, 0, 8'h10, 16'hBEEF, 4'd3, 16'h0000, 0);
      a_req(0, 0, 0, 8'h10, 16'h0000, 4'd5, 16'hBEEF, 0);

      // Byte lanes.
      a_req(1, 1, 0, 8'h11, 16'h0012, 4'd4, 16'h0000, 0);
      a_req(0, 0, 0, 8'h10, 16'h0000, 4'd6, 16'h12EF, 0);
      a_req(0, 1, 1, 8'h10, 16'h0000, 4'd7, 16'hFFEF, 0);
      a_req(0, 1, 0, 8'h10, 16'h0000, 4'd8, 16'h00EF, 0);
      a_req(0, 1, 1, 8'h11, 16'h0000, 4'd9, 16'h0012, 0);
      a_req(0, 1, 1, 8'h21, 16'h0000, 4'd10, 16'hFFCA, 0);

      // Misaligned word accesses; memory must be untouched.
      a_req(1, 0, 0, 8'h21, 16'h1234, 4'd11, 16'h0000, 1);
      a_req(0, 0, 0, 8'h21, 16'h0000, 4'd12, 16'h0000, 1);
      a_req(0, 0, 0, 8'h20, 16'h0000, 4'd13, 16'hCAFE, 0);

      // Back-to-back with req_valid held high.
      pulse_t.delete();
      a_req(0, 0, 0, 8'h10, 16'h0000, 4'd1, 16'h12EF, 0, 1);
      a_req(0, 0, 0, 8'h20, 16'h0000, 4'd2, 16'hCAFE, 0, 1);
      a_req(0, 0, 0, 8'h30, 16'h0000, 4'd3, 16'h5555, 0);
      check("b2b_pulses", 32'(pulse_t.size()), 3);
      if (pulse_t.size() == 3) begin
         check("b2b_spacing0", 32'(pulse_t[1] - pulse_t[0]), LAT_A + 2);
         check("b2b_spacing1", 32'(pulse_t[2] - pulse_t[1]), LAT_A + 2);
      end

      // Reset in the first BUSY cycle aborts the store.
      a_valid = 1; a_write = 1; a_byte = 0; a_signed = 0;
      a_addr = 8'h30; a_wdata = 16'hAAAA; a_rd = 4'd7;
      for (int i = 0; i < 20 && !a_ready; i++) @(negedge clk);
      check("abort_ready_before", 32'(a_ready), 1);
      @(negedge clk);
      rst = 1; a_valid = 0;
      @(negedge clk);
      check("abort_ready_after_rst", 32'(a_ready), 1);
      rst = 0;
      ta.delete();
      repeat (6) @(negedge clk);
      a_req(0, 0, 0, 8'h30, 16'h0000, 4'd9, 16'h5555, 0);

      // Wide configuration.
      b_req(1, 0, 0, 8'h40, 32'hDEADBEEF, 4'd3, 32'h0, 0);
      b_req(0, 0, 0, 8'h40, 32'h0, 4'd5, 32'hDEADBEEF, 0);
      b_req(0, 1, 1, 8'h43, 32'h0, 4'd6, 32'hFFFFFFDE, 0);
      b_req(0, 1, 0, 8'h41, 32'h0, 4'd7, 32'h000000BE, 0);
      b_req(0, 0, 0, 8'h42, 32'h0, 4'd8, 32'h0, 1);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
